dlx_mem_arbiter: RTL and testbench
==================================

Name: dlx_mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the IF fetch port and the MEM-stage data port of the 5-stage DLX pipeline.
- Sequences multi-cycle memory accesses: a grant FSM, a latency counter and a starvation counter.
- Drives stall requests back to the pipeline while a port's access is outstanding.
- Sits between IF_stage/Mem_stage and the memory array.

Parameters:
- MEM_LATENCY, 2, cycles mem_* is held per access; minimum 1; values below 1 are a fatal elaboration error.
- STARVE_MAX, 4, consecutive data grants allowed while if_req waits.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous reset, active-high.
- if_req  in  1  fetch request; held with stable if_addr until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  32  fetched instruction; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for the fetch port.
- dm_req  in  1  data request; held with stable dm_* until dm_ready.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data; valid while dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for the data port.
- mem_cs  out  1  memory select.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- stall_if  out  1  combinational: if_req & ~if_ready.
- stall_mem  out  1  combinational: dm_req & ~dm_ready.
- if_wait_cnt  out  32  statistics; see Optional Feature.
- dm_wait_cnt  out  32  statistics; see Optional Feature.

Behaviour:
- Reset (async, any state, including mid-access):
  - state=IDLE; owner=NONE; lat_cnt=0; starve_cnt=0.
  - mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_rdata=0, dm_rdata=0, if_ready=0, dm_ready=0.
  - An interrupted access is abandoned; no ready pulse is ever issued for it.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, grant decision, evaluated at the edge:
  - DM wins if dm_req & (~if_req | starve_cnt<STARVE_MAX).
  - Otherwise IF wins if if_req.
  - Otherwise stay in IDLE.
- Grant:
  - Latch addr, we and wdata of the winner into mem_* registers; mem_cs=1; lat_cnt=MEM_LATENCY-1; go to ACCESS.
  - mem_we=1 only for a DM store; always 0 for IF.
- ACCESS:
  - mem_* are held stable.
  - lat_cnt decrements each cycle.
  - At lat_cnt==0: sample mem_rdata into the owner's rdata register (loads/fetches only); mem_cs=0, mem_we=0; go to RESP.
- RESP:
  - The owner's ready=1 for exactly one cycle; go to IDLE.
  - Stores pulse dm_ready and leave dm_rdata unchanged.
- Timing: request seen in IDLE at cycle t → mem_cs high cycles t+1..t+MEM_LATENCY → ready high in cycle t+MEM_LATENCY+1.
- Throughput: one access per MEM_LATENCY+2 cycles. No grant is issued in RESP.
- Starvation counter:
  - starve_cnt increments, saturating at STARVE_MAX, on each DM grant made while if_req=1.
  - Clears to 0 on any IF grant.
  - Clears to 0 on a DM grant made while if_req=0.
- Simultaneous requests: DM has priority until starve_cnt==STARVE_MAX, then IF is granted once.
- A requester dropping req mid-access: the access still completes and ready still pulses; the requester ignores it.
- Ready pulses and rdata registers are registered outputs; stall_* are combinational.

Optional Feature:
- Macro: DLX_MEM_ARB_STATS_EN.
- Defined:
  - if_wait_cnt increments each cycle that stall_if=1.
  - dm_wait_cnt increments each cycle that stall_mem=1.
  - Both are 32-bit saturating at 0xFFFFFFFF and cleared by reset.
- Undefined: no counter logic is built; both outputs are tied to 0.

Decomposition:
- Package dlx_mem_arb_pkg:
  - state enum (IDLE/ACCESS/RESP).
  - owner enum (NONE/IF/DM).
  - MEM_LATENCY_MIN=1 constant.
- Sub-module dlx_arb_lat_counter: loadable down-counter with a zero flag, instantiated once for lat_cnt.

Test Plan:
- Fetch alone (MEM_LATENCY=2): if_req@c0, if_addr=0x40, mem_rdata=0x20010005 → mem_cs=1 on c1–c2, mem_addr=0x40, if_ready=1 on c3 only, if_rdata=0x20010005, stall_if=1 on c0–c2.
- Store alone: dm_req, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF @c0 → mem_we=1 on c1–c2 with matching addr/wdata; dm_ready on c3; dm_rdata unchanged.
- Simultaneous if_req and dm_req (load 0x200) @c0 → DM granted first, dm_ready c3; IF granted at c4, if_ready c7.
- Starvation (STARVE_MAX=4): if_req held, dm_req reasserted back-to-back → after 4 DM grants the 5th grant goes to IF; starve_cnt returns to 0.
- Reset asserted in ACCESS (c2 of a fetch) → mem_cs=0 immediately; no if_ready; after release a new fetch completes normally with MEM_LATENCY+1 latency.
- DLX_MEM_ARB_STATS_EN defined, fetch-alone scenario run → if_wait_cnt=3, dm_wait_cnt=0; macro undefined → both read 0.

Source files
------------

// File: rtl/dlx_mem_arb_pkg.sv
// Shared types and constants for the DLX unified-memory arbiter.
package dlx_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM
    } arb_owner_e;

    localparam int MEM_LATENCY_MIN = 1;

endpackage

// File: rtl/dlx_arb_lat_counter.sv
// Loadable down-counter with a zero flag; times how long mem_* is held per access.
module dlx_arb_lat_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dlx_mem_arbiter.sv
// Arbitrates the single-ported unified memory between the IF fetch and MEM data ports.
// Define DLX_MEM_ARB_STATS_EN to build the if_wait_cnt / dm_wait_cnt stall statistics.
module dlx_mem_arbiter
    import dlx_mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int STARVE_MAX  = 4,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ready,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [31:0]       if_wait_cnt,
    output logic [31:0]       dm_wait_cnt
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int SC_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    generate
        if (MEM_LATENCY < MEM_LATENCY_MIN) begin : g_bad_latency
            $fatal(1, "dlx_mem_arbiter: MEM_LATENCY must be at least 1");
        end
    endgenerate

    arb_state_e        r_state;
    arb_owner_e        r_owner;
    logic [SC_W-1:0]   r_starve_cnt;
    logic              r_mem_cs;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_dm_rdata;
    logic              r_if_ready;
    logic              r_dm_ready;

    logic w_grant_dm;
    logic w_grant_if;
    logic w_lat_load;
    logic w_lat_zero;
    logic w_stall_if;
    logic w_stall_mem;

    // DM keeps priority until IF has been passed over STARVE_MAX times in a row.
    assign w_grant_dm = dm_req & (~if_req | (r_starve_cnt < SC_W'(STARVE_MAX)));
    assign w_grant_if = if_req & ~w_grant_dm;
    assign w_lat_load = (r_state == IDLE) & (w_grant_dm | w_grant_if);

    dlx_arb_lat_counter #(.WIDTH(LAT_W)) u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_lat_load),
        .i_load_val (LAT_W'(MEM_LATENCY - 1)),
        .i_dec      (r_state == ACCESS),
        .o_zero     (w_lat_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= OWN_NONE;
            r_starve_cnt <= '0;
            r_mem_cs     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_if_ready   <= 1'b0;
            r_dm_ready   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_dm) begin
                        r_owner     <= OWN_DM;
                        r_mem_cs    <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                        r_state     <= ACCESS;
                        if (!if_req) begin
                            r_starve_cnt <= '0;
                        end else if (r_starve_cnt != SC_W'(STARVE_MAX)) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end else if (w_grant_if) begin
                        r_owner      <= OWN_IF;
                        r_mem_cs     <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= if_addr;
                        r_mem_wdata  <= '0;
                        r_starve_cnt <= '0;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_lat_zero) begin
                        if (r_owner == OWN_IF) begin
                            r_if_rdata <= mem_rdata;
                            r_if_ready <= 1'b1;
                        end else begin
                            if (!r_mem_we) begin
                                r_dm_rdata <= mem_rdata;
                            end
                            r_dm_ready <= 1'b1;
                        end
                        r_mem_cs <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    r_if_ready <= 1'b0;
                    r_dm_ready <= 1'b0;
                    r_owner    <= OWN_NONE;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_stall_if  = if_req & ~r_if_ready;
    assign w_stall_mem = dm_req & ~r_dm_ready;

`ifdef DLX_MEM_ARB_STATS_EN
    logic [31:0] r_if_wait_cnt;
    logic [31:0] r_dm_wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_wait_cnt <= '0;
            r_dm_wait_cnt <= '0;
        end else begin
            if (w_stall_if && (r_if_wait_cnt != '1)) begin
                r_if_wait_cnt <= r_if_wait_cnt + 1'b1;
            end
            if (w_stall_mem && (r_dm_wait_cnt != '1)) begin
                r_dm_wait_cnt <= r_dm_wait_cnt + 1'b1;
            end
        end
    end

    assign if_wait_cnt = r_if_wait_cnt;
    assign dm_wait_cnt = r_dm_wait_cnt;
`else
    assign if_wait_cnt = '0;
    assign dm_wait_cnt = '0;
`endif

    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign dm_rdata  = r_dm_rdata;
    assign dm_ready  = r_dm_ready;
    assign mem_cs    = r_mem_cs;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign stall_if  = w_stall_if;
    assign stall_mem = w_stall_mem;

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Self-checking bench for dlx_mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level model (grant order, completion cycle, memory contents).
module tb_dlx_mem_arbiter;

    localparam int L    = 2;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, dm_ready, mem_cs, mem_we, stall_if, stall_mem;
    logic [31:0] if_wait_cnt, dm_wait_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dlx_mem_arbiter #(.MEM_LATENCY(L), .STARVE_MAX(SMAX), .ADDR_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_ready    (if_ready),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_ready    (dm_ready),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .if_wait_cnt (if_wait_cnt),
        .dm_wait_cnt (dm_wait_cnt)
    );

    // Bench-side memory array; all writes go through this one block.
    logic [31:0] mem_arr [0:1023];
    logic        init_req = 1'b0;

    function automatic logic [31:0] init_val(input int idx);
        if (idx == 16) return 32'h2001_0005;
        return (32'(idx) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 1024; i++) mem_arr[i] <= init_val(i);
        end else if (mem_cs && mem_we) begin
            mem_arr[mem_addr[11:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = mem_arr[mem_addr[11:2]];

    task automatic mem_init();
        init_req = 1'b1;
        @(posedge clk);
        #1 init_req = 1'b0;
    endtask

    task automatic apply_reset();
        if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_req = 0; dm_req = 0;
        #1;
        n_checks++; if (mem_cs !== 1'b0) begin n_errors++; $display("FAIL reset_mem_cs: got %b want 0", mem_cs); end
        n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        n_checks++; if (if_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_if_rdata: got %h want 0", if_rdata); end
        n_checks++; if (dm_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_dm_rdata: got %h want 0", dm_rdata); end
        n_checks++; if (if_ready !== 1'b0 || dm_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got if=%b dm=%b want 0/0", if_ready, dm_ready); end
        n_checks++; if (if_wait_cnt !== 32'h0 || dm_wait_cnt !== 32'h0) begin n_errors++; $display("FAIL reset_wait_cnt: got %0d/%0d want 0/0", if_wait_cnt, dm_wait_cnt); end
    endtask

    task automatic test_fetch_alone();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h40;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++; if (mem_cs !== 1'((c == 1) || (c == 2))) begin n_errors++; $display("FAIL fetch_mem_cs c%0d: got %b", c, mem_cs); end
            n_checks++; if (if_ready !== 1'(c == 3)) begin n_errors++; $display("FAIL fetch_if_ready c%0d: got %b", c, if_ready); end
            n_checks++; if (stall_if !== 1'(c <= 2)) begin n_errors++; $display("FAIL fetch_stall_if c%0d: got %b", c, stall_if); end
            n_checks++; if (dm_ready !== 1'b0) begin n_errors++; $display("FAIL fetch_dm_ready c%0d: got %b want 0", c, dm_ready); end
            if (c == 1 || c == 2) begin
                n_checks++; if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin n_errors++; $display("FAIL fetch_mem_addr c%0d: got %h we=%b want 00000040 we=0", c, mem_addr, mem_we); end
            end
            if (c == 3) begin
                n_checks++; if (if_rdata !== 32'h2001_0005) begin n_errors++; $display("FAIL fetch_if_rdata: got %h want 20010005", if_rdata); end
            end
            @(posedge clk); #1;
            if (c == 3) if_req = 1'b0;
        end
    endtask

    task automatic test_store_alone();
        apply_reset();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++; if (mem_cs !== 1'((c == 1) || (c == 2)) || mem_we !== 1'((c == 1) || (c == 2))) begin
                n_errors++; $display("FAIL store_cs_we c%0d: got cs=%b we=%b", c, mem_cs, mem_we); end
            n_checks++; if (dm_ready !== 1'(c == 3)) begin n_errors++; $display("FAIL store_dm_ready c%0d: got %b", c, dm_ready); end
            if (c == 1 || c == 2) begin
                n_checks++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
                    n_errors++; $display("FAIL store_addr_data c%0d: got %h/%h want 00000100/deadbeef", c, mem_addr, mem_wdata); end
            end
            if (c == 3) begin
                n_checks++; if (dm_rdata !== 32'h0) begin n_errors++; $display("FAIL store_dm_rdata: got %h want 00000000", dm_rdata); end
            end
            @(posedge clk); #1;
            if (c == 3) begin dm_req = 1'b0; dm_we = 1'b0; end
        end
        n_checks++; if (mem_arr[64] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL store_mem_word: got %h want deadbeef", mem_arr[64]); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h44;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            n_checks++; if (dm_ready !== 1'(c == 3)) begin n_errors++; $display("FAIL simul_dm_ready c%0d: got %b", c, dm_ready); end
            n_checks++; if (if_ready !== 1'(c == 7)) begin n_errors++; $display("FAIL simul_if_ready c%0d: got %b", c, if_ready); end
            if (c == 1 || c == 5) begin
                n_checks++; if (mem_cs !== 1'b1 || mem_addr !== ((c == 1) ? 32'h200 : 32'h44)) begin
                    n_errors++; $display("FAIL simul_mem_addr c%0d: got cs=%b addr=%h", c, mem_cs, mem_addr); end
            end
            if (c == 3) begin
                n_checks++; if (dm_rdata !== init_val(128)) begin n_errors++; $display("FAIL simul_dm_rdata: got %h want %h", dm_rdata, init_val(128)); end
            end
            if (c == 7) begin
                n_checks++; if (if_rdata !== init_val(17)) begin n_errors++; $display("FAIL simul_if_rdata: got %h want %h", if_rdata, init_val(17)); end
            end
            @(posedge clk); #1;
            if (c == 3) dm_req = 1'b0;
            if (c == 7) if_req = 1'b0;
        end
    endtask

    // Both ports request continuously: four DM grants, then one IF grant, repeated.
    task automatic test_starvation();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h48;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h204;
        for (int c = 0; c < 40; c++) begin
            logic exp_if, exp_dm;
            exp_if = (c == 19) || (c == 39);
            exp_dm = ((c % 4) == 3) && !exp_if;
            @(negedge clk);
            n_checks++; if (if_ready !== exp_if || dm_ready !== exp_dm) begin
                n_errors++; $display("FAIL starve_ready c%0d: got if=%b dm=%b want if=%b dm=%b", c, if_ready, dm_ready, exp_if, exp_dm); end
            @(posedge clk); #1;
        end
        if_req = 1'b0; dm_req = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (mem_cs !== 1'b1) begin n_errors++; $display("FAIL rst_mid_precond: got mem_cs=%b want 1", mem_cs); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (mem_cs !== 1'b0 || mem_addr !== 32'h0) begin
            n_errors++; $display("FAIL rst_mid_async: got cs=%b addr=%h want 0/0", mem_cs, mem_addr); end
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if (if_ready !== 1'b0 || mem_cs !== 1'b0) begin
                n_errors++; $display("FAIL rst_mid_abandon c%0d: got ready=%b cs=%b want 0/0", c, if_ready, mem_cs); end
        end
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h40;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if (if_ready !== 1'(c == L + 1)) begin n_errors++; $display("FAIL rst_mid_refetch c%0d: got if_ready=%b", c, if_ready); end
            if (c == L + 1) begin
                n_checks++; if (if_rdata !== 32'h2001_0005) begin n_errors++; $display("FAIL rst_mid_rdata: got %h want 20010005", if_rdata); end
            end
            @(posedge clk); #1;
            if (c == L + 1) if_req = 1'b0;
        end
    endtask

    task automatic test_stats();
        logic [31:0] exp_if_w, exp_dm_w;
`ifdef DLX_MEM_ARB_STATS_EN
        exp_if_w = 32'd3; exp_dm_w = 32'd0;
`else
        exp_if_w = 32'd0; exp_dm_w = 32'd0;
`endif
        apply_reset();
        if_req = 1'b1; if_addr = 32'h40;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 3) if_req = 1'b0;
        end
        n_checks++; if (if_wait_cnt !== exp_if_w) begin n_errors++; $display("FAIL stats_if_wait: got %0d want %0d", if_wait_cnt, exp_if_w); end
        n_checks++; if (dm_wait_cnt !== exp_dm_w) begin n_errors++; $display("FAIL stats_dm_wait: got %0d want %0d", dm_wait_cnt, exp_dm_w); end
    endtask

    // Random requesters; the model is a time line of accesses, each L+2 cycles long.
    task automatic test_random();
        logic [31:0] rmem [0:1023];
        int          next_free, grant_cyc, if_rdy_cyc, dm_rdy_cyc, starve;
        logic        if_pend, dm_pend, g_we, exp_if_rdy, exp_dm_rdy;
        logic [31:0] g_addr, g_wdata, if_pending_data, dm_pending_data, exp_if_rdata, exp_dm_rdata;
        logic [31:0] exp_if_w, exp_dm_w;
        apply_reset();
        mem_init();
        for (int i = 0; i < 1024; i++) rmem[i] = init_val(i);
        next_free = 0; grant_cyc = -100; if_rdy_cyc = -1; dm_rdy_cyc = -1; starve = 0;
        if_pend = 0; dm_pend = 0; g_we = 0; g_addr = '0; g_wdata = '0;
        if_pending_data = '0; dm_pending_data = '0; exp_if_rdata = '0; exp_dm_rdata = '0;
        exp_if_w = '0; exp_dm_w = '0;
        for (int c = 0; c < 800; c++) begin
            if (!if_pend && $urandom_range(0, 3) == 0) begin
                if_pend = 1'b1;
                if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                dm_pend  = 1'b1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                dm_wdata = $urandom;
            end
            if_req = if_pend;
            dm_req = dm_pend;
            if (c >= next_free && (if_pend || dm_pend)) begin
                if (dm_pend && (!if_pend || starve < SMAX)) begin
                    starve     = if_pend ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
                    g_addr     = dm_addr; g_we = dm_we; g_wdata = dm_wdata;
                    dm_rdy_cyc = c + L + 1;
                    if (dm_we) rmem[dm_addr[11:2]] = dm_wdata;
                    else       dm_pending_data = rmem[dm_addr[11:2]];
                end else begin
                    starve          = 0;
                    g_addr          = if_addr; g_we = 1'b0; g_wdata = '0;
                    if_rdy_cyc      = c + L + 1;
                    if_pending_data = rmem[if_addr[11:2]];
                end
                grant_cyc = c;
                next_free = c + L + 2;
            end
            exp_if_rdy = (c == if_rdy_cyc);
            exp_dm_rdy = (c == dm_rdy_cyc);
            if (exp_if_rdy) exp_if_rdata = if_pending_data;
            if (exp_dm_rdy && !dm_we) exp_dm_rdata = dm_pending_data;
            @(negedge clk);
            n_checks++; if (if_ready !== exp_if_rdy || dm_ready !== exp_dm_rdy) begin
                n_errors++; $display("FAIL rand_ready c%0d: got if=%b dm=%b want if=%b dm=%b", c, if_ready, dm_ready, exp_if_rdy, exp_dm_rdy); end
            n_checks++; if (mem_cs !== 1'((c > grant_cyc) && (c <= grant_cyc + L))) begin
                n_errors++; $display("FAIL rand_mem_cs c%0d: got %b", c, mem_cs); end
            if ((c > grant_cyc) && (c <= grant_cyc + L)) begin
                n_checks++; if (mem_addr !== g_addr || mem_we !== g_we || (g_we && mem_wdata !== g_wdata)) begin
                    n_errors++; $display("FAIL rand_mem_bus c%0d: got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h",
                                         c, mem_addr, mem_we, mem_wdata, g_addr, g_we, g_wdata); end
            end
            if (exp_if_rdy) begin
                n_checks++; if (if_rdata !== exp_if_rdata) begin n_errors++; $display("FAIL rand_if_rdata c%0d: got %h want %h", c, if_rdata, exp_if_rdata); end
            end
            if (exp_dm_rdy) begin
                n_checks++; if (dm_rdata !== exp_dm_rdata) begin n_errors++; $display("FAIL rand_dm_rdata c%0d: got %h want %h", c, dm_rdata, exp_dm_rdata); end
            end
            n_checks++; if (stall_if !== (if_pend && !exp_if_rdy) || stall_mem !== (dm_pend && !exp_dm_rdy)) begin
                n_errors++; $display("FAIL rand_stall c%0d: got if=%b mem=%b", c, stall_if, stall_mem); end
            if (if_pend && !exp_if_rdy) exp_if_w++;
            if (dm_pend && !exp_dm_rdy) exp_dm_w++;
            if (exp_if_rdy) if_pend = 1'b0;
            if (exp_dm_rdy) dm_pend = 1'b0;
            @(posedge clk); #1;
        end
`ifndef DLX_MEM_ARB_STATS_EN
        exp_if_w = '0; exp_dm_w = '0;
`endif
        n_checks++; if (if_wait_cnt !== exp_if_w || dm_wait_cnt !== exp_dm_w) begin
            n_errors++; $display("FAIL rand_wait_cnt: got %0d/%0d want %0d/%0d", if_wait_cnt, dm_wait_cnt, exp_if_w, exp_dm_w); end
        if_req = 1'b0; dm_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        mem_init();
        test_reset();
        test_fetch_alone();
        test_store_alone();
        test_simultaneous();
        test_starvation();
        test_reset_mid_access();
        test_stats();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
